// File: rtl/bit_destuffer.sv
`default_nettype none
// ============================================================================
// Module   : bit_destuffer
// Purpose  : Removes the zero a transmitter inserts after RUN_LEN consecutive
//            ones in a serial stream. Forwards ordinary bits with one cycle of
//            latency, and pulses a flag for each removed stuffed zero and for
//            each stuffing violation. Saturating statistics counters track
//            both events.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous active-high reset
//            clr        - synchronous clear of run state, outputs and counters
//            din        - serial stuffed input bit
//            din_valid  - qualifies din
//            dout       - de-stuffed output bit (holds when dout_valid=0)
//            dout_valid - qualifies dout
//            stuff_drop - one-cycle pulse: a stuffed zero was removed
//            stuff_err  - one-cycle pulse: a one arrived where a zero was due
//            stuff_cnt  - saturating count of removed stuffed zeros
//            err_cnt    - saturating count of stuffing violations
// Revision : 1.0 - initial release
// ============================================================================
module bit_destuffer #(
    parameter int RUN_LEN = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             din,
    input  logic             din_valid,
    output logic             dout,
    output logic             dout_valid,
    output logic             stuff_drop,
    output logic             stuff_err,
    output logic [CNT_W-1:0] stuff_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_EXPECT = 1'b1
    } state_t;

    localparam logic [3:0]       c_RUN_LEN = 4'(RUN_LEN);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t           r_state;
    logic [3:0]       r_run;
    logic             r_dout;
    logic             r_dout_valid;
    logic             r_stuff_drop;
    logic             r_stuff_err;
    logic [CNT_W-1:0] r_stuff_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [3:0]       w_run_inc;

    assign w_run_inc = r_run + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_run        <= 4'd0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_stuff_drop <= 1'b0;
            r_stuff_err  <= 1'b0;
            r_stuff_cnt  <= '0;
            r_err_cnt    <= '0;
        end else if (clr) begin
            // clr wins over a coincident accepted bit, which is discarded
            r_state      <= ST_RUN;
            r_run        <= 4'd0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_stuff_drop <= 1'b0;
            r_stuff_err  <= 1'b0;
            r_stuff_cnt  <= '0;
            r_err_cnt    <= '0;
        end else begin
            // Pulses default low; only an accepted bit can raise one of them
            r_dout_valid <= 1'b0;
            r_stuff_drop <= 1'b0;
            r_stuff_err  <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    ST_RUN: begin
                        r_dout       <= din;
                        r_dout_valid <= 1'b1;
                        if (din) begin
                            r_run <= w_run_inc;
                            // The one completing the run is still data
                            if (w_run_inc == c_RUN_LEN) begin
                                r_state <= ST_EXPECT;
                            end
                        end else begin
                            r_run <= 4'd0;
                        end
                    end
                    ST_EXPECT: begin
                        // Stuffed bit slot: never forwarded; a one here means
                        // the stream is out of step, so restart the run anyway
                        r_state <= ST_RUN;
                        r_run   <= 4'd0;
                        if (!din) begin
                            r_stuff_drop <= 1'b1;
                            if (r_stuff_cnt != c_CNT_MAX) begin
                                r_stuff_cnt <= r_stuff_cnt + 1'b1;
                            end
                        end else begin
                            r_stuff_err <= 1'b1;
                            if (r_err_cnt != c_CNT_MAX) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_RUN;
                        r_run   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign stuff_drop = r_stuff_drop;
    assign stuff_err  = r_stuff_err;
    assign stuff_cnt  = r_stuff_cnt;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bit_destuffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_destuffer
// Purpose  : Self-checking bench for bit_destuffer (RUN_LEN=5, CNT_W=4).
//            A queue-based reference model tracks the accepted data bits
//            since the last resynchronisation point and decides from the
//            trailing ones whether the next accepted bit is a stuffed slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_destuffer;

    localparam int RUN_LEN = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             din;
    logic             din_valid;
    logic             dout;
    logic             dout_valid;
    logic             stuff_drop;
    logic             stuff_err;
    logic [CNT_W-1:0] stuff_cnt;
    logic [CNT_W-1:0] err_cnt;

    bit_destuffer #(
        .RUN_LEN (RUN_LEN),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .stuff_drop (stuff_drop),
        .stuff_err  (stuff_err),
        .stuff_cnt  (stuff_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int   q_bits[$];
    logic m_dout, m_vld, m_drop, m_err;
    int   m_scnt, m_ecnt;
    int   ones_seen, drops_seen;

    function automatic void model_reset();
        q_bits.delete();
        m_dout = 1'b0; m_vld = 1'b0; m_drop = 1'b0; m_err = 1'b0;
        m_scnt = 0;    m_ecnt = 0;
    endfunction

    // Trailing ones among data bits accepted since the last resync
    function automatic int trailing_ones();
        int t = 0;
        for (int i = q_bits.size() - 1; i >= 0; i--) begin
            if (q_bits[i] != 1) break;
            t++;
        end
        return t;
    endfunction

    function automatic void model_edge(input logic c, input logic v, input logic d);
        if (c) begin
            model_reset();
            return;
        end
        m_vld = 1'b0; m_drop = 1'b0; m_err = 1'b0;
        if (!v) return;
        if (trailing_ones() >= RUN_LEN) begin
            q_bits.delete();
            if (d == 1'b0) begin
                m_drop = 1'b1;
                if (m_scnt < CNT_MAX) m_scnt++;
            end else begin
                m_err = 1'b1;
                if (m_ecnt < CNT_MAX) m_ecnt++;
            end
        end else begin
            q_bits.push_back(int'(d));
            if (q_bits.size() > RUN_LEN) void'(q_bits.pop_front());
            m_dout = d;
            m_vld  = 1'b1;
        end
    endfunction

    task automatic check(input string tag);
        n_cmp++;
        assert (dout === m_dout) else begin
            n_fail++; $error("FAIL %s dout: got %0b exp %0b", tag, dout, m_dout);
        end
        n_cmp++;
        assert (dout_valid === m_vld) else begin
            n_fail++; $error("FAIL %s dout_valid: got %0b exp %0b", tag, dout_valid, m_vld);
        end
        n_cmp++;
        assert (stuff_drop === m_drop) else begin
            n_fail++; $error("FAIL %s stuff_drop: got %0b exp %0b", tag, stuff_drop, m_drop);
        end
        n_cmp++;
        assert (stuff_err === m_err) else begin
            n_fail++; $error("FAIL %s stuff_err: got %0b exp %0b", tag, stuff_err, m_err);
        end
        n_cmp++;
        assert (stuff_cnt === CNT_W'(m_scnt)) else begin
            n_fail++; $error("FAIL %s stuff_cnt: got %0d exp %0d", tag, stuff_cnt, m_scnt);
        end
        n_cmp++;
        assert (err_cnt === CNT_W'(m_ecnt)) else begin
            n_fail++; $error("FAIL %s err_cnt: got %0d exp %0d", tag, err_cnt, m_ecnt);
        end
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 ns later
    task automatic step(input string tag, input logic c, input logic v, input logic d);
        clr = c; din_valid = v; din = d;
        @(posedge clk);
        #1;
        model_edge(c, v, d);
        check(tag);
        if (dout_valid && dout) ones_seen++;
        if (stuff_drop) drops_seen++;
    endtask

    task automatic send(input string tag, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b0, 1'b1, bits[i]);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; din = 1'b0; din_valid = 1'b0;
        ones_seen = 0; drops_seen = 0;
        model_reset();
        #1;
        check("reset_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("idle", 1'b0, 1'b0, 1'b0);

        // 0,1,1,1,1,1,0,1 : stuffed zero removed
        send("drop_seq", 32'b0111_1101, 8);
        step("drop_idle", 1'b0, 1'b0, 1'b0);

        // 1 x6 : violation, resync
        step("clr1", 1'b1, 1'b0, 1'b0);
        send("err_seq", 32'b11_1111, 6);
        step("err_idle", 1'b0, 1'b0, 1'b0);

        // Run spanning a din_valid gap
        step("clr2", 1'b1, 1'b0, 1'b0);
        send("gap_a", 32'b11, 2);
        for (int i = 0; i < 3; i++) step("gap", 1'b0, 1'b0, 1'b1);
        send("gap_b", 32'b1110, 4);

        // Async reset mid-run discards the partial run
        step("clr3", 1'b1, 1'b0, 1'b0);
        send("pre_rst", 32'b1111, 4);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_mid");
        rst = 1'b0;
        step("post_rst_idle", 1'b0, 1'b0, 1'b0);
        drops_seen = 0;
        send("post_rst", 32'b10, 2);
        n_cmp++;
        assert (drops_seen == 0) else begin
            n_fail++; $error("FAIL post_rst_drops: got %0d exp 0", drops_seen);
        end

        // Counter saturation: 20 stuffed frames into a 4-bit counter
        step("clr4", 1'b1, 1'b0, 1'b0);
        ones_seen = 0;
        for (int r = 0; r < 20; r++) send("sat", 32'b11_1110, 6);
        n_cmp++;
        assert (ones_seen == 100) else begin
            n_fail++; $error("FAIL sat_ones: got %0d exp 100", ones_seen);
        end
        n_cmp++;
        assert (stuff_cnt === 4'd15) else begin
            n_fail++; $error("FAIL sat_cnt: got %0d exp 15", stuff_cnt);
        end

        // clr in EXPECT with a coincident stuffed zero
        step("clr5", 1'b1, 1'b0, 1'b0);
        send("to_expect", 32'b1_1111, 5);
        step("clr_in_expect", 1'b1, 1'b1, 1'b0);
        send("after_clr", 32'b11_1110, 6);
        n_cmp++;
        assert (stuff_cnt === 4'd1) else begin
            n_fail++; $error("FAIL after_clr_cnt: got %0d exp 1", stuff_cnt);
        end

        // Randomised stream, biased towards long runs of ones
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
